// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for load-use, taken-branch redirect and data-memory wait
// hazards, with a wait watchdog and saturating stall/redirect counters.
module pipeline_hazard_ctrl #(
    parameter int WAIT_MAX = 255,
    parameter int WAIT_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       fd_rs1_i,
    input  logic [4:0]       fd_rs2_i,
    input  logic             fd_uses_rs1_i,
    input  logic             fd_uses_rs2_i,
    input  logic [4:0]       de_rd_i,
    input  logic             de_mem_read_i,
    input  logic             ex_branch_taken_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ack_i,
    output logic             pc_en_o,
    output logic             fd_en_o,
    output logic             fd_flush_o,
    output logic             de_en_o,
    output logic             de_flush_o,
    output logic             em_en_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);
    localparam logic [1:0] RUN = 2'd0, MEM_WAIT = 2'd1, HALT = 2'd2;
    logic [1:0] state;
    logic [WAIT_W-1:0] wait_cnt;
    logic hazard, mem_stall, live, redirect, load_use;
    // live: the pipeline advances this cycle, so redirect/load-use rules apply
    always_comb begin
        hazard = de_mem_read_i && (de_rd_i != 5'd0) &&
                 ((fd_uses_rs1_i && fd_rs1_i == de_rd_i) || (fd_uses_rs2_i && fd_rs2_i == de_rd_i));
        mem_stall = (state == RUN) && dmem_req_i && !dmem_ack_i;
        live = !rst_i && (((state == RUN) && !mem_stall) || ((state == MEM_WAIT) && dmem_ack_i));
        redirect = live && ex_branch_taken_i;
        load_use = live && !ex_branch_taken_i && hazard;
        pc_en_o = live && !load_use;
        fd_en_o = live && !load_use;
        de_en_o = live;
        em_en_o = live;
        fd_flush_o = rst_i || redirect;
        de_flush_o = rst_i || redirect || load_use;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= RUN;
            wait_cnt <= '0;
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
            mem_timeout_o <= 1'b0;
        end else begin
            if (!pc_en_o && state != HALT && stall_cnt_o != '1)
                stall_cnt_o <= stall_cnt_o + 1'b1;
            if (redirect && flush_cnt_o != '1)
                flush_cnt_o <= flush_cnt_o + 1'b1;
            if (mem_stall) begin
                state <= MEM_WAIT;
                wait_cnt <= WAIT_W'(1);
            end else if (state == MEM_WAIT) begin
                if (dmem_ack_i) begin
                    state <= RUN;
                    wait_cnt <= '0;
                end else if (wait_cnt == WAIT_W'(WAIT_MAX)) begin
                    state <= HALT;
                    mem_timeout_o <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed stimulus against a rule-level model, checked every cycle on two
// parameterisations (16-bit and 2-bit counters, watchdog limit 4).
module tb_pipeline_hazard_ctrl;
    localparam int WMAX = 4;
    localparam int M_RUN = 0, M_WAIT = 1, M_HALT = 2;
    logic clk = 1'b0;
    logic rst;
    logic [4:0] fd_rs1, fd_rs2, de_rd;
    logic fd_uses_rs1, fd_uses_rs2, de_mem_read, ex_branch_taken, dmem_req, dmem_ack;
    logic a_pc, a_fd, a_ffl, a_de, a_dfl, a_em, a_to;
    logic [15:0] a_stall, a_flush;
    logic b_pc, b_fd, b_ffl, b_de, b_dfl, b_em, b_to;
    logic [1:0] b_stall, b_flush;
    int checks = 0, failures = 0;
    int m_state, m_wait, m_stall, m_flush;
    bit m_to, armed = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.WAIT_MAX(WMAX), .WAIT_W(8), .CNT_W(16)) dut_a (
        .clk_i(clk), .rst_i(rst), .fd_rs1_i(fd_rs1), .fd_rs2_i(fd_rs2),
        .fd_uses_rs1_i(fd_uses_rs1), .fd_uses_rs2_i(fd_uses_rs2), .de_rd_i(de_rd),
        .de_mem_read_i(de_mem_read), .ex_branch_taken_i(ex_branch_taken),
        .dmem_req_i(dmem_req), .dmem_ack_i(dmem_ack),
        .pc_en_o(a_pc), .fd_en_o(a_fd), .fd_flush_o(a_ffl), .de_en_o(a_de), .de_flush_o(a_dfl),
        .em_en_o(a_em), .mem_timeout_o(a_to), .stall_cnt_o(a_stall), .flush_cnt_o(a_flush));

    pipeline_hazard_ctrl #(.WAIT_MAX(WMAX), .WAIT_W(8), .CNT_W(2)) dut_b (
        .clk_i(clk), .rst_i(rst), .fd_rs1_i(fd_rs1), .fd_rs2_i(fd_rs2),
        .fd_uses_rs1_i(fd_uses_rs1), .fd_uses_rs2_i(fd_uses_rs2), .de_rd_i(de_rd),
        .de_mem_read_i(de_mem_read), .ex_branch_taken_i(ex_branch_taken),
        .dmem_req_i(dmem_req), .dmem_ack_i(dmem_ack),
        .pc_en_o(b_pc), .fd_en_o(b_fd), .fd_flush_o(b_ffl), .de_en_o(b_de), .de_flush_o(b_dfl),
        .em_en_o(b_em), .mem_timeout_o(b_to), .stall_cnt_o(b_stall), .flush_cnt_o(b_flush));

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endfunction

    // Model: outputs follow the hazard rules in priority order; counters tracked as plain integers.
    always @(negedge clk) begin
        bit hz, e_pc, e_fd, e_ffl, e_de, e_dfl, e_em;
        hz = de_mem_read && de_rd != 0 &&
             ((fd_uses_rs1 && fd_rs1 == de_rd) || (fd_uses_rs2 && fd_rs2 == de_rd));
        if (rst) {e_pc, e_fd, e_de, e_em, e_ffl, e_dfl} = 6'b000011;
        else if (m_state == M_HALT) {e_pc, e_fd, e_de, e_em, e_ffl, e_dfl} = 6'b000000;
        else if (!dmem_ack && (m_state == M_WAIT || dmem_req)) {e_pc, e_fd, e_de, e_em, e_ffl, e_dfl} = 6'b000000;
        else if (ex_branch_taken) {e_pc, e_fd, e_de, e_em, e_ffl, e_dfl} = 6'b111111;
        else if (hz) {e_pc, e_fd, e_de, e_em, e_ffl, e_dfl} = 6'b001101;
        else {e_pc, e_fd, e_de, e_em, e_ffl, e_dfl} = 6'b111100;
        if (armed) begin
            chk("a_pc_en", a_pc, e_pc); chk("a_fd_en", a_fd, e_fd); chk("a_fd_flush", a_ffl, e_ffl);
            chk("a_de_en", a_de, e_de); chk("a_de_flush", a_dfl, e_dfl); chk("a_em_en", a_em, e_em);
            chk("a_timeout", a_to, m_to);
            chk("a_stall_cnt", a_stall, m_stall > 65535 ? 65535 : m_stall);
            chk("a_flush_cnt", a_flush, m_flush > 65535 ? 65535 : m_flush);
            chk("b_pc_en", b_pc, e_pc); chk("b_fd_flush", b_ffl, e_ffl); chk("b_de_flush", b_dfl, e_dfl);
            chk("b_timeout", b_to, m_to);
            chk("b_stall_cnt", b_stall, m_stall > 3 ? 3 : m_stall);
            chk("b_flush_cnt", b_flush, m_flush > 3 ? 3 : m_flush);
        end
        if (rst) begin
            m_state = M_RUN; m_wait = 0; m_stall = 0; m_flush = 0; m_to = 0; armed = 1;
        end else begin
            if (!e_pc && m_state != M_HALT) m_stall++;
            if (e_ffl) m_flush++;
            if (m_state == M_RUN && dmem_req && !dmem_ack) begin
                m_state = M_WAIT; m_wait = 1;
            end else if (m_state == M_WAIT) begin
                if (dmem_ack) begin m_state = M_RUN; m_wait = 0; end
                else if (m_wait == WMAX) begin m_state = M_HALT; m_to = 1; end
                else m_wait++;
            end
        end
    end

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        {fd_rs1, fd_rs2, de_rd} = '0;
        {fd_uses_rs1, fd_uses_rs2, de_mem_read, ex_branch_taken, dmem_req, dmem_ack} = '0;
    endtask

    task automatic load_use(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2);
        de_mem_read = 1; de_rd = rd; fd_rs1 = rs1; fd_rs2 = rs2; fd_uses_rs1 = u1; fd_uses_rs2 = u2;
    endtask

    initial begin
        rst = 1; idle();
        #2;
        chk("rst_pc_en", a_pc, 0); chk("rst_fd_flush", a_ffl, 1); chk("rst_de_flush", a_dfl, 1);
        tick(2);
        rst = 0;
        #2;
        chk("init_stall", a_stall, 0); chk("init_flush", a_flush, 0); chk("init_to", a_to, 0);
        chk("idle_pc_en", a_pc, 1);
        tick();
        load_use(5, 5, 0, 1, 0);
        #2;
        chk("lu_pc_en", a_pc, 0); chk("lu_fd_en", a_fd, 0); chk("lu_de_flush", a_dfl, 1); chk("lu_de_en", a_de, 1);
        tick();
        chk("lu_stall_cnt", a_stall, 1);
        idle();
        #2;
        chk("lu_after_pc_en", a_pc, 1); chk("lu_after_de_flush", a_dfl, 0);
        tick();
        load_use(0, 0, 0, 1, 0);
        #2 chk("x0_pc_en", a_pc, 1);
        tick();
        load_use(7, 1, 7, 0, 0);
        #2 chk("unused_rs2_pc_en", a_pc, 1);
        tick();
        chk("no_stall_cnt", a_stall, 1);
        load_use(5, 5, 0, 1, 0);
        ex_branch_taken = 1;
        #2;
        chk("br_fd_flush", a_ffl, 1); chk("br_de_flush", a_dfl, 1); chk("br_pc_en", a_pc, 1);
        tick();
        chk("br_flush_cnt", a_flush, 1); chk("br_stall_cnt", a_stall, 1);
        idle();
        dmem_req = 1;
        for (int i = 0; i < 3; i++) begin
            #2; chk("mw_pc_en", a_pc, 0); chk("mw_em_en", a_em, 0); chk("mw_de_en", a_de, 0);
            tick();
        end
        dmem_ack = 1;
        #2;
        chk("ack_pc_en", a_pc, 1); chk("ack_em_en", a_em, 1); chk("ack_fd_en", a_fd, 1);
        tick();
        chk("mw_stall_cnt", a_stall, 4);
        idle();
        #2 chk("mw_run_pc_en", a_pc, 1);
        dmem_req = 1; ex_branch_taken = 1;
        #1 chk("mw_br_fd_flush", a_ffl, 0);
        tick();
        dmem_ack = 1;
        #2;
        chk("ack_br_fd_flush", a_ffl, 1); chk("ack_br_pc_en", a_pc, 1);
        tick();
        chk("ack_br_flush_cnt", a_flush, 2); chk("ack_br_stall_cnt", a_stall, 5);
        idle();
        dmem_ack = 1;
        #2 chk("stray_ack_pc_en", a_pc, 1);
        tick();
        chk("stray_ack_stall", a_stall, 5);
        idle();
        dmem_req = 1;
        tick(4);
        chk("wd_before_to", a_to, 0);
        tick();
        chk("wd_to", a_to, 1); chk("wd_stall", a_stall, 10); chk("wd_b_sat", b_stall, 3);
        dmem_ack = 1;
        #2;
        chk("halt_pc_en", a_pc, 0); chk("halt_fd_flush", a_ffl, 0); chk("halt_de_flush", a_dfl, 0);
        tick(2);
        chk("halt_hold_to", a_to, 1); chk("halt_hold_stall", a_stall, 10); chk("halt_pc_en2", a_pc, 0);
        rst = 1;
        #2 chk("halt_rst_flush", a_ffl, 1);
        tick();
        rst = 0; idle();
        #2;
        chk("post_rst_stall", a_stall, 0); chk("post_rst_flush", a_flush, 0);
        chk("post_rst_to", a_to, 0); chk("post_rst_pc_en", a_pc, 1);
        load_use(3, 0, 3, 0, 1);
        tick(5);
        chk("sat_b_stall", b_stall, 3); chk("sat_a_stall", a_stall, 5);
        idle();
        dmem_req = 1;
        tick(2);
        rst = 1;
        #2;
        chk("mid_rst_fd_flush", a_ffl, 1); chk("mid_rst_de_flush", a_dfl, 1); chk("mid_rst_pc_en", a_pc, 0);
        tick();
        rst = 0; idle();
        #2 chk("mid_rst_run_pc_en", a_pc, 1);
        tick();
        chk("mid_rst_stall", a_stall, 0); chk("mid_rst_to", a_to, 0);
        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
